// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with branch/jump redirect handling
// Issues one read at a time and hands each instruction to decode with a PC tag.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  input  logic        branch_enable,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump_enable,
  input  logic [25:0] jump_target
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] target;

  // Targets are relative to the last instruction handed to decode.
  assign redirect   = jump_enable | (branch_enable & branch_taken);
  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_tgt   = {pc_plus4[31:28], jump_target, 2'b00};
  assign target     = jump_enable ? jump_tgt : branch_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      addr_q    <= RESET_PC;
      next_pc_q <= RESET_PC;
      instr_q   <= 32'd0;
      pc_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      next_pc_q <= next_pc_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    next_pc_d   = next_pc_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          if (imem_ack) begin
            addr_d = target;
          end else begin
            // Read stays outstanding; remember where to go once it drains.
            state_d   = DROP;
            next_pc_d = target;
          end
        end else if (imem_ack) begin
          state_d   = HOLD;
          instr_d   = imem_rdata;
          pc_d      = addr_q;
          next_pc_d = addr_q + 32'd4;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (redirect) begin
          state_d = FETCH;
          addr_d  = target;
        end else if (instr_ready) begin
          state_d = FETCH;
          addr_d  = next_pc_q;
        end
      end
      DROP: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = FETCH;
          addr_d  = redirect ? target : next_pc_q;
        end else if (redirect) begin
          next_pc_d = target;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign imem_addr = addr_q;
  assign instr_out = instr_q;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized scoreboard bench for fetch_unit
// Expected instruction stream comes from a PC-sequence model of branch/jump rules.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_ack, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, instr_out, pc_out;
  logic        branch_enable, branch_taken, jump_enable;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;

  logic        aux_rst_n;
  logic        w_req, w_ack, w_valid, w_ready;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  logic        j_req, j_ack, j_valid, j_ready, j_je;
  logic [31:0] j_addr, j_rdata, j_instr, j_pc;
  logic [25:0] j_jt;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic je,
                                             input logic [15:0] off, input logic [25:0] jt);
    logic [31:0] seq, sx;
    seq = pc + 32'd4;
    sx  = {{16{off[15]}}, off};
    if (je) return (seq & 32'hF000_0000) | ({6'd0, jt} << 2);
    return seq + sx * 32'd4;
  endfunction

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_out(pc_out),
    .branch_enable(branch_enable), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump_enable(jump_enable), .jump_target(jump_target)
  );

  assign w_ack   = w_req;
  assign w_rdata = memf(w_addr);
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(aux_rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .instr_out(w_instr),
    .instr_valid(w_valid), .instr_ready(w_ready), .pc_out(w_pc),
    .branch_enable(1'b0), .branch_taken(1'b0), .branch_offset(16'd0),
    .jump_enable(1'b0), .jump_target(26'd0)
  );

  assign j_ack   = j_req;
  assign j_rdata = memf(j_addr);
  fetch_unit #(.RESET_PC(32'h1000_0008)) u_jmp (
    .clk(clk), .rst_n(aux_rst_n), .imem_req(j_req), .imem_addr(j_addr),
    .imem_ack(j_ack), .imem_rdata(j_rdata), .instr_out(j_instr),
    .instr_valid(j_valid), .instr_ready(j_ready), .pc_out(j_pc),
    .branch_enable(1'b0), .branch_taken(1'b0), .branch_offset(16'd0),
    .jump_enable(j_je), .jump_target(j_jt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  bit   scb_on = 1'b0;
  int   deliveries = 0;

  // Monitor: pops the scoreboard whenever decode consumes an instruction.
  logic        mon_redir, prev_pend, prev_stall;
  logic [31:0] prev_addr, prev_pc, prev_ins;
  exp_t        mon_e;
  initial begin
    prev_pend  = 1'b0;
    prev_stall = 1'b0;
    prev_addr  = 32'd0;
    prev_pc    = 32'd0;
    prev_ins   = 32'd0;
    forever begin
      @(negedge clk);
      if (scb_on) begin
        mon_redir = jump_enable | (branch_enable & branch_taken);
        if (prev_pend) begin
          chk("req_held", 32'(imem_req), 32'd1);
          chk("addr_stable", imem_addr, prev_addr);
        end
        if (prev_stall) begin
          chk("stall_valid", 32'(instr_valid), 32'd1);
          chk("stall_pc", pc_out, prev_pc);
          chk("stall_instr", instr_out, prev_ins);
          chk("stall_noreq", 32'(imem_req), 32'd0);
        end
        if (instr_valid && (instr_ready || mon_redir)) begin
          chk("scb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("scb_pc", pc_out, mon_e.pc);
            chk("scb_instr", instr_out, mon_e.ins);
            deliveries++;
          end
        end
        prev_pend  = imem_req && !imem_ack;
        prev_addr  = imem_addr;
        prev_stall = instr_valid && !instr_ready && !mon_redir;
        prev_pc    = pc_out;
        prev_ins   = instr_out;
      end else begin
        prev_pend  = 1'b0;
        prev_stall = 1'b0;
      end
    end
  end

  logic [31:0] nxt_pc, last_pc;
  logic        have_last, redir;
  int          wait_cnt;

  initial begin
    rst_n = 1'b0; aux_rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
    branch_enable = 1'b0; branch_taken = 1'b0; branch_offset = 16'd0;
    jump_enable = 1'b0; jump_target = 26'd0;
    w_ready = 1'b0; j_ready = 1'b0; j_je = 1'b0; j_jt = 26'd0;
    tick(); tick();

    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);

    // Zero-wait memory, decode always ready.
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) begin
        chk("seq_req", 32'(imem_req), 32'd1);
        chk("seq_addr", imem_addr, 32'(4 * (t / 2)));
        chk("seq_valid0", 32'(instr_valid), 32'd0);
      end else begin
        chk("seq_valid1", 32'(instr_valid), 32'd1);
        chk("seq_pc", pc_out, 32'(4 * (t / 2)));
        chk("seq_instr", instr_out, memf(32'(4 * (t / 2))));
      end
      imem_ack = imem_req; imem_rdata = memf(imem_addr); instr_ready = 1'b1;
      tick();
    end

    // Jump together with ack in FETCH: data dropped, address redirected.
    imem_ack = 1'b1; imem_rdata = memf(imem_addr); jump_enable = 1'b1; jump_target = 26'h40;
    tick();
    jump_enable = 1'b0; imem_ack = 1'b0;
    chk("jack_valid", 32'(instr_valid), 32'd0);
    chk("jack_addr", imem_addr, 32'h100);
    imem_ack = 1'b1; imem_rdata = memf(32'h100);
    tick();
    imem_ack = 1'b0;
    chk("h100_valid", 32'(instr_valid), 32'd1);
    chk("h100_pc", pc_out, 32'h100);

    branch_enable = 1'b1; branch_taken = 1'b1; branch_offset = 16'hFFFE;
    tick();
    branch_enable = 1'b0; branch_taken = 1'b0;
    chk("br_addr", imem_addr, 32'hFC);
    chk("br_valid", 32'(instr_valid), 32'd0);

    imem_ack = 1'b1; imem_rdata = memf(32'hFC);
    tick();
    imem_ack = 1'b0; jump_enable = 1'b1; jump_target = 26'h4;
    tick();
    jump_enable = 1'b0;
    chk("f10_addr", imem_addr, 32'h10);

    // Redirect to 0x200 with the 0x10 read acked three cycles later.
    jump_enable = 1'b1; jump_target = 26'h80;
    tick();
    jump_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drop_addr", imem_addr, 32'h10);
      chk("drop_req", 32'(imem_req), 32'd1);
      chk("drop_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    chk("drop_addr3", imem_addr, 32'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("drained_valid", 32'(instr_valid), 32'd0);
    chk("drained_addr", imem_addr, 32'h200);

    // Reset asserted while a stale read is outstanding.
    jump_enable = 1'b1; jump_target = 26'h10;
    tick();
    jump_enable = 1'b0;
    chk("drop2_addr", imem_addr, 32'h200);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd1);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", instr_out, 32'd0);
    chk("arst_pc", pc_out, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hBAAD_F00D;
    tick();
    imem_ack = 1'b0; rst_n = 1'b1;
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("late_ack_addr", imem_addr, 32'd0);
    imem_ack = 1'b1; imem_rdata = memf(32'd0);
    tick();
    imem_ack = 1'b0; instr_ready = 1'b0;
    chk("post_rst_pc", pc_out, 32'd0);
    chk("post_rst_instr", instr_out, memf(32'd0));

    // Wrap-around and jump-region instances.
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    chk("jmp_rst_addr", j_addr, 32'h1000_0008);
    aux_rst_n = 1'b1;
    tick();
    chk("jmp_hold_pc", j_pc, 32'h1000_0008);
    j_je = 1'b1; j_jt = 26'h40;
    for (int i = 0; i < 5; i++) begin
      chk("wrap_valid", 32'(w_valid), 32'd1);
      chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
      chk("wrap_instr", w_instr, memf(32'hFFFF_FFFC));
      chk("wrap_noreq", 32'(w_req), 32'd0);
      tick();
      if (i == 0) begin
        j_je = 1'b0;
        chk("jmp_addr", j_addr, 32'h1000_0100);
        chk("jmp_valid", 32'(j_valid), 32'd0);
      end
    end
    w_ready = 1'b1;
    tick();
    chk("wrap_addr", w_addr, 32'd0);
    chk("wrap_req", 32'(w_req), 32'd1);

    // Randomized phase against the PC-sequence model.
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    exp_q.push_back({32'd0, memf(32'd0)});
    nxt_pc = 32'd0; last_pc = 32'd0; have_last = 1'b0;
    wait_cnt = $urandom_range(0, 3);
    scb_on = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (imem_req) begin
        if (wait_cnt == 0) begin
          imem_ack = 1'b1; imem_rdata = memf(imem_addr); wait_cnt = $urandom_range(0, 3);
        end else begin
          imem_ack = 1'b0; imem_rdata = $urandom; wait_cnt--;
        end
      end else begin
        imem_ack = ($urandom_range(0, 3) == 0); imem_rdata = $urandom;
      end
      jump_enable = 1'b0; branch_enable = 1'b0; branch_taken = 1'b0;
      branch_offset = 16'($urandom); jump_target = 26'($urandom);
      if (have_last && $urandom_range(0, instr_valid ? 3 : 7) == 0) begin
        case ($urandom_range(0, 3))
          0: jump_enable = 1'b1;
          1: begin branch_enable = 1'b1; branch_taken = 1'b1; end
          2: begin jump_enable = 1'b1; branch_enable = 1'b1; branch_taken = 1'b1; end
          default: begin branch_enable = 1'($urandom); branch_taken = ~branch_enable; end
        endcase
      end
      instr_ready = instr_valid ? ($urandom_range(0, 2) != 0) : 1'($urandom);
      redir = jump_enable | (branch_enable & branch_taken);
      if (instr_valid && (instr_ready || redir)) begin
        last_pc   = nxt_pc;
        have_last = 1'b1;
        nxt_pc    = redir ? ref_target(last_pc, jump_enable, branch_offset, jump_target)
                          : last_pc + 32'd4;
        exp_q.push_back({nxt_pc, memf(nxt_pc)});
      end else if (redir) begin
        nxt_pc = ref_target(last_pc, jump_enable, branch_offset, jump_target);
        exp_q[exp_q.size() - 1] = {nxt_pc, memf(nxt_pc)};
      end
      tick();
    end
    scb_on = 1'b0;
    chk("deliveries_min", 32'(deliveries >= 100), 32'd1);
    chk("scb_pending", 32'(exp_q.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: byte address of the outstanding read.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: read data valid this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: read data, qualified by imem_ack.
REQ-008 The block SHALL have port instr_out, output, 32 bits: instruction to the control unit; opcode is [31:26].
REQ-009 The block SHALL have port instr_valid, output, 1 bit: instr_out holds a valid instruction.
REQ-010 The block SHALL have port instr_ready, input, 1 bit: decode stage accepts instr_out this cycle.
REQ-011 The block SHALL have port pc_out, output, 32 bits: PC of the instruction in instr_out.
REQ-012 The block SHALL have port branch_enable, input, 1 bit: control unit branch decode.
REQ-013 The block SHALL have port branch_taken, input, 1 bit: branch condition met.
REQ-014 The block SHALL have port branch_offset, input, 16 bits: signed word offset.
REQ-015 The block SHALL have port jump_enable, input, 1 bit: control unit jump decode.
REQ-016 The block SHALL have port jump_target, input, 26 bits: word index of the jump target.

Function
REQ-017 The block SHALL define redirect as jump_enable | (branch_enable & branch_taken), sampled every cycle; when both jump and branch are true, jump SHALL win.
REQ-018 The branch target SHALL be pc_out + 4 + (sign-extend(branch_offset) << 2), computed modulo 2^32.
REQ-019 The jump target SHALL be {pc_out_plus4[31:28], jump_target, 2'b00}.
REQ-020 Sequential PC increment SHALL be +4 modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-021 The FSM SHALL have states FETCH, HOLD and DROP.
- FETCH: imem_req = 1.
- HOLD: instr_valid = 1.
- DROP: imem_req = 1; a stale read is outstanding.
REQ-022 FETCH & imem_ack & !redirect SHALL move to HOLD, capturing instr_out = imem_rdata, pc_out = imem_addr, and next_pc = imem_addr + 4.
REQ-023 FETCH & redirect & !imem_ack SHALL move to DROP and load next_pc = target; imem_addr SHALL stay on the outstanding address.
REQ-024 FETCH & redirect & imem_ack SHALL discard the data and stay in FETCH; imem_addr = target from the next cycle.
REQ-025 HOLD & redirect SHALL move to FETCH at target, with instr_valid low next cycle; redirect SHALL have priority over instr_ready.
REQ-026 HOLD & instr_ready & !redirect SHALL move to FETCH at next_pc.
REQ-027 HOLD & !instr_ready SHALL hold instr_out and pc_out stable.
REQ-028 DROP & imem_ack SHALL discard the data and move to FETCH at next_pc.
REQ-029 A redirect in DROP SHALL overwrite next_pc, with the last redirect winning.
REQ-030 imem_addr SHALL be stable while imem_req is high and ack has not been received; imem_req SHALL never be withdrawn before imem_ack.
REQ-031 Zero-wait memory (ack in the same cycle as req) SHALL give one instruction per two cycles.
REQ-032 imem_ack outside FETCH or DROP SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately set state = FETCH, imem_addr = RESET_PC, imem_req = 1, instr_valid = 0, instr_out = 0, pc_out = 0.
REQ-034 Reset asserted mid-transaction SHALL abandon any outstanding read; the first request after release SHALL be RESET_PC.

Verification
REQ-035 Reset release, ack in the same cycle each fetch, instr_ready = 1 -> imem_addr sequence 0, 4, 8, with instr_valid every other cycle and pc_out matching.
REQ-036 pc_out = 32'h100 in HOLD, branch_enable = branch_taken = 1, branch_offset = 16'hFFFE -> next imem_addr = 32'hFC.
REQ-037 pc_out = 32'h1000_0008, jump_enable = 1, jump_target = 26'h40 -> next imem_addr = 32'h1000_0100.
REQ-038 Redirect to 32'h200 while a read of 32'h10 is pending with ack 3 cycles later -> imem_addr holds 32'h10 until ack; data is discarded and instr_valid stays 0; next request is 32'h200.
REQ-039 instr_ready = 0 for 5 cycles in HOLD -> instr_out and pc_out stable and imem_req = 0; RESET_PC = 32'hFFFF_FFFC -> second fetch at 32'h0.
REQ-040 rst_n pulsed low while in DROP -> outputs immediately take their REQ-033 values, and the late ack is ignored.
